// File: rtl/mem_ctl_rr_arbiter.sv
// Round-robin arbiter sharing one memory-control channel among N_REQ requesters.
// Optional macro ARB_TIMEOUT_EN adds an ISSUE watchdog that aborts after TIMEOUT_CYC cycles.
package MuxParam_pkg;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    op_e        op;
  } mem_ctl_st_t;
endpackage

module MuxParam #(
  parameter type T   = logic,
  parameter int  SEL = 1
) (
  input  logic [SEL-1:0] sel,
  input  T               din [2**SEL],
  output T               dout
);
  assign dout = din[sel];
endmodule

module mem_ctl_rr_arbiter
  import MuxParam_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int SW         = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  mem_ctl_st_t       req_ctl [N_REQ],
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  done,
  output logic [7:0]        rdata,
  output logic              err,
  output logic [SW-1:0]     sel,
  output logic              mem_valid,
  output mem_ctl_st_t       mem_ctl,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_ctl_rr_arbiter: N_REQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [SW-1:0]      sel_q, sel_d, last_q, last_d;
  logic               mem_valid_q, mem_valid_d;
  mem_ctl_st_t        mem_ctl_q, mem_ctl_d;

  logic               win_found;
  logic [SW-1:0]      win_idx;
  logic [SW:0]        cand;
  mem_ctl_st_t        mux_in [2**SW];
  mem_ctl_st_t        mux_out;

  function automatic logic [N_REQ-1:0] onehot(input logic [SW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Search starts one past the last winner and wraps, giving rotating priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_q} + (SW+1)'(i);
      if (cand >= (SW+1)'(N_REQ)) cand = cand - (SW+1)'(N_REQ);
      if (!win_found && req[cand[SW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SW-1:0];
      end
    end
  end

  // Pad the mux to a power of two; unused slots are never selected.
  for (genvar g = 0; g < 2**SW; g++) begin : g_mux_in
    if (g < N_REQ) begin : g_real
      assign mux_in[g] = req_ctl[g];
    end else begin : g_pad
      assign mux_in[g] = '0;
    end
  end

  MuxParam #(.T(mem_ctl_st_t), .SEL(SW)) u_mux (
    .sel  (win_idx),
    .din  (mux_in),
    .dout (mux_out)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    sel_d       = sel_q;
    last_d      = last_q;
    mem_valid_d = mem_valid_q;
    mem_ctl_d   = mem_ctl_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          sel_d       = win_idx;
          gnt_d       = onehot(win_idx);
          mem_ctl_d   = mux_out;
          mem_valid_d = 1'b1;
          state_d     = S_ISSUE;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rdata_d     = (mem_ctl_q.op == OP_RD) ? mem_rdata : 8'h00;
          done_d      = onehot(sel_q);
          last_d      = sel_q;
          state_d     = S_RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          mem_valid_d = 1'b0;
          err_d       = 1'b1;
          rdata_d     = 8'h00;
          done_d      = onehot(sel_q);
          last_d      = sel_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        done_d    = '0;
        gnt_d     = '0;
        rdata_d   = 8'h00;
        mem_ctl_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      sel_q       <= '0;
      last_q      <= SW'(N_REQ - 1);
      mem_valid_q <= 1'b0;
      mem_ctl_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      mem_valid_q <= mem_valid_d;
      mem_ctl_q   <= mem_ctl_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sel       = sel_q;
  assign mem_valid = mem_valid_q;
  assign mem_ctl   = mem_ctl_q;
endmodule

// File: tb/tb_mem_ctl_rr_arbiter.sv
// Directed scoreboard bench for mem_ctl_rr_arbiter: expected completions are queued
// when a request is driven and popped when the DUT pulses done.
module tb_mem_ctl_rr_arbiter;
  import MuxParam_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req;
  mem_ctl_st_t       req_ctl [4];
  logic [3:0]        gnt, done;
  logic [7:0]        rdata;
  logic              err;
  logic [1:0]        sel;
  logic              mem_valid;
  mem_ctl_st_t       mem_ctl;
  logic              mem_ready;
  logic [7:0]        mem_rdata;

  typedef struct {
    int         idx;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   issue_cyc = 0;
  int   prev_cyc  = 0;

  mem_ctl_rr_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_ctl   (req_ctl),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .sel       (sel),
    .mem_valid (mem_valid),
    .mem_ctl   (mem_ctl),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_issue(input int idx, input logic [7:0] addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 50);
    chk("issue_valid", 32'(mem_valid), 1);
    chk("issue_gnt", 32'(gnt), 32'(1 << idx));
    chk("issue_sel", 32'(sel), 32'(idx));
    chk("issue_addr", 32'(mem_ctl.addr), 32'(addr));
    issue_cyc = cyc;
  endtask

  task automatic wait_done();
    exp_t e;
    int   n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 4'b0 && n < 50);
    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("done_vec", 32'(done), 32'(1 << e.idx));
      chk("done_gnt", 32'(gnt), 32'(1 << e.idx));
      chk("rdata", 32'(rdata), 32'(e.rdata));
    end
    chk("err_quiet", 32'(err), 0);
    chk("valid_low", 32'(mem_valid), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("gnt_clear", 32'(gnt), 0);
    chk("rdata_clear", 32'(rdata), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) req_ctl[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_ctl", 32'(mem_ctl), 0);

    // Single read to requester 2.
    rst = 1'b0;
    req = 4'b0100;
    req_ctl[2] = '{addr: 8'd45, data: 8'd100, op: OP_RD};
    mem_ready = 1'b1;
    mem_rdata = 8'hA5;
    exp_q.push_back('{idx: 2, rdata: 8'hA5});
    wait_issue(2, 8'd45);
    chk("t1_op", 32'(mem_ctl.op), 32'(OP_RD));
    wait_done();
    req = '0;

    // All four requesting writes from reset: order 0,1,2,3,0 with 3-cycle spacing.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      req_ctl[i] = '{addr: 8'(10 + i), data: 8'(20 + i), op: OP_WR};
    mem_rdata = 8'h5A;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back('{idx: k % 4, rdata: 8'h00});
    for (int k = 0; k < 5; k++) begin
      wait_issue(k % 4, 8'(10 + (k % 4)));
      if (k > 0) chk("grant_spacing", 32'(issue_cyc - prev_cyc), 3);
      prev_cyc = issue_cyc;
      wait_done();
    end
    req = '0;

    // Fairness: serve 1, then with 0 and 1 requesting, 0 wins before 1.
    req_ctl[1] = '{addr: 8'd77, data: 8'd1, op: OP_RD};
    req_ctl[0] = '{addr: 8'd88, data: 8'd2, op: OP_RD};
    mem_rdata = 8'h3C;
    req = 4'b0010;
    exp_q.push_back('{idx: 1, rdata: 8'h3C});
    wait_issue(1, 8'd77);
    wait_done();
    req = 4'b0011;
    exp_q.push_back('{idx: 0, rdata: 8'h3C});
    exp_q.push_back('{idx: 1, rdata: 8'h3C});
    wait_issue(0, 8'd88);
    wait_done();
    wait_issue(1, 8'd77);
    wait_done();
    req = '0;

    // Stalled ISSUE with the winner's command changing underneath.
    req_ctl[2] = '{addr: 8'd60, data: 8'd7, op: OP_RD};
    mem_ready = 1'b0;
    mem_rdata = 8'h99;
    req = 4'b0100;
    exp_q.push_back('{idx: 2, rdata: 8'h99});
    wait_issue(2, 8'd60);
    req_ctl[2] = '{addr: 8'd133, data: 8'd200, op: OP_RD};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(mem_valid), 1);
      chk("stall_addr", 32'(mem_ctl.addr), 60);
      chk("stall_data", 32'(mem_ctl.data), 7);
      chk("stall_done", 32'(done), 0);
    end
    mem_ready = 1'b1;
    wait_done();
    req = '0;

    // Asynchronous reset mid-ISSUE, then requester 0 has first priority.
    req_ctl[3] = '{addr: 8'd30, data: 8'd3, op: OP_WR};
    mem_ready = 1'b0;
    req = 4'b1000;
    wait_issue(3, 8'd30);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_valid), 0);
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sel", 32'(sel), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'h42;
    req = 4'b1001;
    exp_q.push_back('{idx: 0, rdata: 8'h42});
    exp_q.push_back('{idx: 3, rdata: 8'h00});
    wait_issue(0, 8'd88);
    wait_done();
    wait_issue(3, 8'd30);
    wait_done();
    req = '0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: mem_ready stuck low aborts after 16 ISSUE cycles.
    mem_ready = 1'b0;
    mem_rdata = 8'hEE;
    req = 4'b0010;
    wait_issue(1, 8'd77);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("tmo_wait_done", 32'(done), 0);
      chk("tmo_wait_err", 32'(err), 0);
    end
    @(negedge clk);
    chk("tmo_done", 32'(done), 32'(4'b0010));
    chk("tmo_err", 32'(err), 1);
    chk("tmo_rdata", 32'(rdata), 0);
    chk("tmo_valid", 32'(mem_valid), 0);
    @(negedge clk);
    chk("tmo_err_pulse", 32'(err), 0);
    chk("tmo_done_pulse", 32'(done), 0);
    chk("tmo_gnt_clear", 32'(gnt), 0);
    req = '0;
`endif

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_ctl_rr_arbiter.md
Name: mem_ctl_rr_arbiter

Overview:
Round-robin arbiter that shares one memory-control channel between N_REQ requesters. Each requester presents a MuxParam_pkg::mem_ctl_st_t command (addr, data, op RD/WR). The winner's command is routed through a MuxParam instance (T = mem_ctl_st_t, SEL = clog2(N_REQ)), registered, and issued to the memory with a valid/ready handshake. The read response is returned to the winner with a one-cycle done pulse.

Parameters:
N_REQ, 4, number of requesters; must be >= 2. Select width SW = $clog2(N_REQ).
TIMEOUT_CYC, 16, cycles to wait for mem_ready before aborting. Used only when ARB_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request level; held until the matching done
req_ctl  input  N_REQ x mem_ctl_st_t  per-requester command (unpacked array)
gnt  output  N_REQ  one-hot grant; all-zero when idle
done  output  N_REQ  one-cycle completion pulse to the granted requester
rdata  output  8  read data for the completed RD; valid while done is high
err  output  1  one-cycle timeout pulse (ARB_TIMEOUT_EN only)
sel  output  SW  index of the current or last winner
mem_valid  output  1  command valid to memory
mem_ctl  output  mem_ctl_st_t  registered command to memory
mem_ready  input  1  memory accepts the command; for RD, mem_rdata is valid in the same cycle
mem_rdata  input  8  memory read data

Behaviour:
- Reset values (asynchronous, take effect immediately): state=IDLE, gnt=0, done=0, rdata=0, err=0, sel=0, mem_valid=0, mem_ctl='0 (addr 0, data 0, op RD), last-winner pointer=N_REQ-1 so requester 0 has first priority.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req bit is set, the winner w is the first set bit searched from (last+1) mod N_REQ upward, with wrap-around.
  - At that edge: sel<=w, gnt<=onehot(w), mem_ctl<=req_ctl[w] (taken through the MuxParam output), mem_valid<=1, go to ISSUE.
  - If no req bit is set, remain in IDLE with all outputs at their reset values except sel and the pointer, which keep their last values.
- ISSUE:
  - mem_valid=1; mem_ctl and gnt are held stable until mem_ready is sampled high.
  - On the edge where mem_ready=1: mem_valid<=0, rdata<=mem_rdata if op==RD, else rdata<=0, done[w]<=1, last<=w, go to RESP.
- RESP:
  - Lasts exactly one cycle; done[w]=1 and gnt still asserted.
  - Next edge: done<=0, gnt<=0, return to IDLE.
- Latency: req sampled at edge E0 -> mem_valid high after E0. With mem_ready=1 immediately, done is high for the cycle after E1. Minimum spacing between back-to-back grants is 3 cycles (IDLE, ISSUE, RESP).
- Once granted, the transaction always completes. A req drop or a req_ctl change during ISSUE/RESP is ignored, because the command is registered at grant.
- Changes to requests other than the winner's have no effect until the next IDLE evaluation.
- mem_ready is ignored outside ISSUE.
- For WR transactions, rdata stays 0.
- Fairness: a continuously requesting requester is granted within N_REQ transactions.
- Reset during ISSUE or RESP aborts the transaction: no done pulse, and mem_valid drops asynchronously.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ISSUE and increments on each ISSUE cycle without mem_ready. When it reaches TIMEOUT_CYC:
  - mem_valid<=0, err<=1 for one cycle, done[w]<=1 with rdata<=0.
  - last<=w, go to RESP.
  - If mem_ready=1 in the same cycle, it takes priority and there is no err.
- Not defined: no counter; ISSUE waits indefinitely; err is tied to 0.

Test Plan:
- Single RD: req=4'b0100, req_ctl[2]={addr 45, data 100, RD}, mem_ready=1, mem_rdata=8'hA5 -> gnt=4'b0100, mem_ctl.addr=45, done[2] pulses once, rdata=8'hA5, then gnt=0.
- All four requesting continuously (WR commands) from reset -> grant order 0,1,2,3,0; each done pulse is exactly one cycle; grants are 3 cycles apart.
- Fairness: after requester 1 has been served, req=4'b0011 -> requester 0 is granted next, not 1.
- mem_ready held low for 5 cycles in ISSUE while req_ctl[w] is changed to {133, 200, RD} -> mem_ctl keeps its originally latched value; done follows the first cycle with mem_ready high.
- rst asserted mid-ISSUE -> mem_valid, gnt and done go to 0 immediately; after release, req=4'b1001 -> requester 0 is granted first.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=16 and mem_ready stuck at 0 -> after 16 ISSUE cycles, err pulses once, done[w]=1, rdata=0, return to IDLE.
